// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_padder
//  Description : Reads NUM_OF_WORDS message words from memory and streams the
//                SHA-256 padded message as 16-word blocks over valid/ready.
//                Optional build macro SHA256_PAD_BSWAP_EN byte-swaps memory words.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [3:0]        out_word_idx,
  output logic              out_last_block,
  output logic              out_last_word,
  output logic              busy,
  output logic              done
);

  localparam int          C_NB        = (NUM_OF_WORDS + 2 + 16) / 16;
  localparam int          C_TOTAL     = 16 * C_NB;
  localparam logic [15:0] C_N         = 16'(NUM_OF_WORDS);
  localparam logic [15:0] C_LAST_K    = 16'(C_TOTAL - 1);
  localparam logic [11:0] C_LAST_BLK  = 12'(C_NB - 1);
  localparam logic [31:0] C_LEN       = 32'(NUM_OF_WORDS * 32);
  localparam logic [31:0] C_PAD_START = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAP  = 3'd2,
    S_EMIT = 3'd3,
    S_PAD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_k;
  logic [15:0] w_k_nxt;
  logic [15:0] w_k_inc;
  logic [31:0] r_out_word;
  logic [31:0] w_out_word_nxt;
  logic [31:0] w_cap_word;
  logic        w_hs;

  // The length's upper word is always zero, so only k==N and k==TOTAL-1 are non-zero.
  function automatic logic [31:0] pad_word(input logic [15:0] k);
    if (k == C_N)
      return C_PAD_START;
    else if (k == C_LAST_K)
      return C_LEN;
    else
      return 32'h0;
  endfunction

`ifdef SHA256_PAD_BSWAP_EN
  assign w_cap_word = {mem_read_data[7:0],   mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign w_cap_word = mem_read_data;
`endif

  assign out_valid = (r_state == S_EMIT) || (r_state == S_PAD);
  assign w_hs      = out_valid && out_ready;
  assign w_k_inc   = r_k + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_k        <= 16'd0;
      r_out_word <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_out_word <= w_out_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_out_word_nxt = r_out_word;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_REQ;
          w_k_nxt     = 16'd0;
        end
      end
      S_REQ: w_state_nxt = S_CAP;
      S_CAP: begin
        w_out_word_nxt = w_cap_word;
        w_state_nxt    = S_EMIT;
      end
      S_EMIT: begin
        if (w_hs) begin
          w_k_nxt = w_k_inc;
          if (w_k_inc == C_N) begin
            w_state_nxt    = S_PAD;
            w_out_word_nxt = pad_word(w_k_inc);
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_PAD: begin
        if (w_hs) begin
          w_k_nxt        = w_k_inc;
          w_out_word_nxt = pad_word(w_k_inc);
          if (r_k == C_LAST_K)
            w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the counter may still hold TOTAL from the last message; present the base address.
  assign mem_addr       = message_addr + ((r_state == S_IDLE) ? {ADDR_W{1'b0}} : ADDR_W'(r_k));
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign out_word       = r_out_word;
  assign out_word_idx   = r_k[3:0];
  assign out_last_block = out_valid && (r_k[15:4] == C_LAST_BLK);
  assign out_last_word  = out_valid && (r_k == C_LAST_K);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);

endmodule
`default_nettype wire
